demux_key_fifo: RTL
===================

Name: demux_key_fifo

Overview:
- Keyed 1-to-N demultiplexer; the write-side counterpart of the key/value mux library (MuxKey selects one of N by key; this block steers one input to one of N by key).
- Accepts a (key, data) word on a valid/ready input port and appends it to a 2-entry FIFO for channel `key`.
- Each channel drains independently through its own valid/ready output.
- Sits between a single producer (switch/keyboard front end) and per-channel consumers (LED/seven-segment drivers).

Parameters:
- NR_CH, 4, number of output channels (1..2^KEY_LEN).
- KEY_LEN, 2, key width in bits.
- DATA_LEN, 2, data width in bits.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous reset, active-low; sampled at posedge clk.
- s_valid  input  1  input word present.
- s_ready  output  1  block will accept the input word this cycle.
- s_key  input  KEY_LEN  destination channel index.
- s_data  input  DATA_LEN  payload.
- m_valid  output  NR_CH  bit i: channel i head entry available.
- m_ready  input  NR_CH  bit i: consumer i takes head this cycle.
- m_data  output  NR_CH*DATA_LEN  channel i head at bits [DATA_LEN*(i+1)-1 : DATA_LEN*i].
- ch_level  output  NR_CH*2  channel i occupancy (0..2), same slicing with width 2.
- drop_cnt  output  CNT_W  count of accepted words whose key >= NR_CH.

Behaviour:
- Reset: a posedge with rst==0 empties every FIFO. Forced values after that edge:
  - m_valid=0, m_data=0, ch_level=0, drop_cnt=0.
  - s_ready=0 combinationally whenever rst==0.
- Reset mid-operation: all stored words are discarded and in-flight handshakes are ignored. The first accept is possible in the cycle rst returns to 1.
- Definitions:
  - accept = s_valid & s_ready.
  - pop[i] = m_valid[i] & m_ready[i].
- s_ready is combinational from s_key and the registered state only:
  - s_ready=1 if s_key >= NR_CH (drop path).
  - Otherwise s_ready=1 if level[s_key] < 2.
  - s_ready does NOT depend on m_ready. A full channel refuses input even while it is being popped in the same cycle.
  - s_valid and s_key are allowed to change without a handshake. s_ready simply follows s_key.
- Per-channel FIFO: 2 entries, head and tail order preserved.
  - Accept at edge N makes the word visible on m_data/m_valid from cycle N+1. Latency is 1 cycle; there is no combinational pass-through.
  - Push and pop on the same channel in the same cycle: level is unchanged. The head advances and the new word lands behind the remaining entry.
  - Push into level 1 with simultaneous pop: the new word becomes head next cycle.
  - Pops on different channels in the same cycle are fully independent.
- m_valid[i] = (level[i] != 0). m_data slice i = head entry of channel i. The slice holds its last value when empty and must not be relied on; the bench checks it only when m_valid is 1.
- m_data and m_valid are registered or register-derived. They hold stable while m_valid=1 and m_ready=0.
- Drop path: an accepted word with s_key >= NR_CH is discarded and drop_cnt increments by 1. The counter saturates at 2^CNT_W-1 and never wraps. This path is unreachable when NR_CH == 2^KEY_LEN.
- m_ready on a channel with m_valid=0 has no effect.
- No X propagation: all state is reset. Unused key codes must not write any FIFO.

Decomposition:
- Shared package holds:
  - localparam FIFO_DEPTH=2 and LEVEL_W=2.
  - A function to extract slice i of a packed bus.
- Sub-module demux_ch_fifo: one 2-entry FIFO.
  - Ports: clk, rst, push, push_data, pop, head, level, full.
  - Instantiated NR_CH times in a generate loop.
- The top level holds key decode, s_ready select, and drop_cnt.

Test Plan:
- Reset sweep:
  - Stimulus: fill all channels, then assert rst=0 for 1 cycle with s_valid=1.
  - Response: after the edge m_valid=4'b0000, ch_level=0, drop_cnt=0, and s_ready=0 during the reset cycle.
- Routing:
  - Stimulus: send (key,data) = (0,2'b01), (1,2'b10), (2,2'b11), (3,2'b00) back-to-back with m_ready=0.
  - Response: m_valid=4'b1111 one cycle after the last accept, and m_data = {2'b00, 2'b11, 2'b10, 2'b01}.
- Full/backpressure:
  - Stimulus: push key=2 with data 1, 2, then 3, m_ready=0.
  - Response: the third word sees s_ready=0 and ch_level[2]=2. After one pop the head is 2 and the third word is accepted.
- Simultaneous push/pop:
  - Stimulus: channel 1 at level 1 (head=2'b01); push 2'b11 with m_ready[1]=1 in the same cycle.
  - Response: ch_level[1] stays 1 and the next head is 2'b11.
  - Also check: with the channel full plus a pop in the same cycle, s_ready=0.
- Drop counter:
  - Stimulus: NR_CH=3, send key=3 260 times.
  - Response: s_ready=1 throughout, no m_valid change, and drop_cnt saturates at 255.
- Random soak:
  - Stimulus: random s_valid/s_key/s_data/m_ready for 10k cycles.
  - Response: per-channel order matches a scoreboard queue, no loss or duplication, and level never exceeds 2.

Source files
------------

// File: rtl/demux_key_fifo_pkg.sv
// Shared constants and helpers for the keyed demultiplexer and its per-channel FIFOs.
// Each channel FIFO holds two entries. Buses are packed with channel 0 in the least significant slice.
package demux_key_fifo_pkg;

    localparam int FIFO_DEPTH  = 2;
    localparam int LEVEL_W     = 2;
    localparam int SLICE_BUS_W = 64;

    // Returns slice idx of width w from a packed bus. The result is zero-extended to 32 bits.
    function automatic logic [31:0] slice_of(input logic [SLICE_BUS_W-1:0] bus,
                                             input int idx,
                                             input int w);
        logic [SLICE_BUS_W-1:0] shifted;
        shifted = bus >> (idx * w);
        return shifted[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/demux_ch_fifo.sv
// Two-entry FIFO for one output channel. The head entry is registered, so data reaches
// the output one cycle after a push. A push on a full FIFO is ignored, and so is a pop
// on an empty FIFO.
module demux_ch_fifo
    import demux_key_fifo_pkg::*;
#(
    parameter int DATA_LEN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATA_LEN-1:0] push_data,
    input  logic                pop,
    output logic [DATA_LEN-1:0] head,
    output logic [LEVEL_W-1:0]  level,
    output logic                full
);

    logic [DATA_LEN-1:0] head_q;
    logic [DATA_LEN-1:0] tail_q;
    logic [LEVEL_W-1:0]  level_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            case (level_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= push_data;
                        level_q <= 2'd1;
                    end
                end
                2'd1: begin
                    // Push and pop together: the old head leaves and the new word takes its place.
                    if (push && pop) begin
                        head_q <= push_data;
                    end else if (push) begin
                        tail_q  <= push_data;
                        level_q <= 2'd2;
                    end else if (pop) begin
                        level_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        level_q <= 2'd1;
                    end
                end
                default: level_q <= '0;
            endcase
        end
    end

    assign head  = head_q;
    assign level = level_q;
    assign full  = (level_q == LEVEL_W'(FIFO_DEPTH));

endmodule

// File: rtl/demux_key_fifo.sv
// Keyed 1-to-N demultiplexer. Each input word is steered by its key into a per-channel
// two-entry FIFO. Words whose key has no channel are counted and dropped.
module demux_key_fifo
    import demux_key_fifo_pkg::*;
#(
    parameter int NR_CH    = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [KEY_LEN-1:0]          s_key,
    input  logic [DATA_LEN-1:0]         s_data,
    output logic [NR_CH-1:0]            m_valid,
    input  logic [NR_CH-1:0]            m_ready,
    output logic [NR_CH*DATA_LEN-1:0]   m_data,
    output logic [NR_CH*LEVEL_W-1:0]    ch_level,
    output logic [CNT_W-1:0]            drop_cnt
);

    // Handshake: a word moves on a port at a posedge where valid and ready are both 1.
    // s_ready is decided only by s_key and registered occupancy, never by m_ready. A full
    // channel therefore refuses input even in a cycle where it is being drained.
    // valid and key may change freely while ready is 0.

    logic                key_oob;
    logic [LEVEL_W-1:0]  sel_level;
    logic                accept;
    logic [NR_CH-1:0]    push;
    logic [NR_CH-1:0]    pop;
    logic [NR_CH-1:0]    full;

    always_comb begin
        key_oob   = (int'(s_key) >= NR_CH);
        sel_level = LEVEL_W'(slice_of(SLICE_BUS_W'(ch_level), int'(s_key), LEVEL_W));
        s_ready   = rst & (key_oob | (sel_level < LEVEL_W'(FIFO_DEPTH)));
        accept    = s_valid & s_ready;
    end

    for (genvar i = 0; i < NR_CH; i++) begin : g_ch
        assign push[i]    = accept & ~key_oob & (int'(s_key) == i);
        assign m_valid[i] = (ch_level[i*LEVEL_W +: LEVEL_W] != '0);
        assign pop[i]     = m_valid[i] & m_ready[i];

        demux_ch_fifo #(
            .DATA_LEN (DATA_LEN)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data (s_data),
            .pop       (pop[i]),
            .head      (m_data[i*DATA_LEN +: DATA_LEN]),
            .level     (ch_level[i*LEVEL_W +: LEVEL_W]),
            .full      (full[i])
        );
    end

    // Keys without a channel are swallowed. The drop counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (accept && key_oob && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule
